prebuf_arbiter: RTL and testbench
=================================

Name: prebuf_arbiter

Overview:
- Arbitrates one single-port block RAM (16-bit data, 12-bit address, 3840 words; the preBuffer line store) between two requesters.
- Requester 1 is a pixel write stream using valid/ready; the write address is generated internally as a wrapping pointer.
- Requester 2 is a random-access reader using req/gnt, with data returned one cycle after grant.
- Sits between the capture front end, the downstream filter/reader and the spbram instance. Drives its ce/we/addr/d and consumes its q.

Parameters:
- DWIDTH, 16, data width; must match the RAM.
- AWIDTH, 12, address width; must match the RAM.
- MEM_SIZE, 3840, number of RAM words; the write pointer wraps here and read addresses at or above it are illegal.

Ports:
- clk  in  1  single clock; also clocks the RAM.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write beat present.
- wr_data  in  DWIDTH  write pixel.
- wr_sof  in  1  beat is the first of a frame; qualified by wr_valid.
- wr_ready  out  1  write beat accepted this cycle.
- wr_wrap  out  1  registered one-cycle pulse: the previous accepted beat was written at MEM_SIZE-1.
- wr_ptr  out  AWIDTH  next write address.
- rd_req  in  1  read request.
- rd_addr  in  AWIDTH  read address; held stable while rd_req=1 and rd_gnt=0.
- rd_gnt  out  1  read accepted this cycle.
- rd_valid  out  1  rd_data valid; one cycle after rd_gnt.
- rd_err  out  1  qualifies rd_valid: the address was >= MEM_SIZE.
- rd_data  out  DWIDTH  read result.
- ram_ce  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AWIDTH  RAM address.
- ram_d  out  DWIDTH  RAM write data.
- ram_q  in  DWIDTH  RAM read data; registered in the RAM, so valid one cycle after a ce&!we access.

Behaviour:
- Arbitration is combinational in cycle T:
  - Only wr_valid=1 -> grant write.
  - Only rd_req=1 -> grant read.
  - Both -> grant the side opposite to the last_grant register.
  - Neither -> no grant; last_grant unchanged.
- last_grant register:
  - Updated at the clock edge on every grant.
  - Reset value is READ, so the first tie goes to write.
  - Worst-case wait for either side is 1 cycle under continuous contention.
- wr_ready = write granted; rd_gnt = read granted. The two are never both 1.
- Write grant drives the RAM:
  - ram_ce=1, ram_we=1, ram_d=wr_data.
  - ram_addr = 0 if wr_sof=1, else wr_ptr.
- Write pointer update on an accepted beat:
  - wr_ptr <= (written address == MEM_SIZE-1) ? 0 : written address + 1.
  - wr_wrap <= 1 on that edge when the written address was MEM_SIZE-1; otherwise 0 at every edge.
- wr_sof with a beat that is not granted has no effect; the producer holds the beat.
- Legal read grant (rd_addr < MEM_SIZE): ram_ce=1, ram_we=0, ram_addr=rd_addr.
- Illegal read grant (rd_addr >= MEM_SIZE): rd_gnt=1 but ram_ce=0; the RAM is untouched.
- Read return:
  - rd_valid <= rd_gnt (registered); rd_err <= the illegal flag of that grant (registered).
  - rd_data = ram_q when rd_err=0; rd_data = 0 when rd_err=1.
  - rd_data is don't-care when rd_valid=0.
- No grant: ram_ce=0, ram_we=0, ram_addr=0, ram_d=0.
- Back-to-back reads: one result per cycle; the read side carries no backpressure.
- Reset (asynchronous, any time):
  - wr_ptr=0, wr_wrap=0, rd_valid=0, rd_err=0, last_grant=READ.
  - A read in flight when reset hits is dropped; its rd_valid never appears.
  - Combinational outputs follow their inputs while rst is high; the RAM contents are not cleared.

Test Plan:
- Reset, then 5 write beats of 0x0011..0x0015 with rd_req=0 -> wr_ready=1 every cycle; RAM addresses 0..4 written; wr_ptr=5.
- Read addresses 2 then 4 on consecutive cycles -> rd_gnt on both; rd_valid on the next two cycles with rd_data 0x0013 then 0x0015; rd_err=0.
- wr_valid and rd_req held high together for 6 cycles -> grants alternate W,R,W,R,W,R starting with W; 3 writes and 3 reads; each read returns the correct data.
- Write 3840 beats, then one more -> wr_wrap pulses one cycle after the beat at address 3839; the 3841st beat is written at address 0; wr_ptr=1.
- Beat with wr_sof=1 while wr_ptr=100 -> written at address 0; wr_ptr=1. The same beat stalled by a read grant leaves wr_ptr=100 until it is accepted.
- Read rd_addr=3840 -> rd_gnt=1 with ram_ce=0; next cycle rd_valid=1, rd_err=1, rd_data=0. Then assert rst the cycle after a legal rd_gnt -> rd_valid stays 0.

Source files
------------

// File: rtl/prebuf_arbiter.sv
// Shares one single-port preBuffer RAM between a wrapping-pointer write stream and a random-access reader.
// Grants are combinational and read data returns one cycle after rd_gnt. On a tie the side that lost last time wins. The reader sees no backpressure beyond its grant.
module prebuf_arbiter #(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 12,
    parameter int MEM_SIZE = 3840
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              wr_sof,
    output logic              wr_ready,
    output logic              wr_wrap,
    output logic [AWIDTH-1:0] wr_ptr,
    input  logic              rd_req,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic              rd_err,
    output logic [DWIDTH-1:0] rd_data,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_d,
    input  logic [DWIDTH-1:0] ram_q
);

    typedef enum logic {GNT_WRITE = 1'b0, GNT_READ = 1'b1} gnt_e;

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);
    // One extra bit so the bound also works when MEM_SIZE == 2**AWIDTH.
    localparam logic [AWIDTH:0]   SIZE_EXT  = (AWIDTH+1)'(MEM_SIZE);

    gnt_e              last_grant_q, last_grant_d;
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic              wr_wrap_q, wr_wrap_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;

    logic              grant_wr;
    logic              grant_rd;
    logic              rd_illegal;
    logic [AWIDTH-1:0] wr_addr;

    always_comb begin
        grant_wr   = wr_valid & (~rd_req | (last_grant_q == GNT_READ));
        grant_rd   = rd_req & ~grant_wr;
        rd_illegal = ({1'b0, rd_addr} >= SIZE_EXT);
        wr_addr    = wr_sof ? '0 : wr_ptr_q;

        ram_ce   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_d    = '0;
        if (grant_wr) begin
            ram_ce   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wr_addr;
            ram_d    = wr_data;
        end else if (grant_rd && !rd_illegal) begin
            ram_ce   = 1'b1;
            ram_addr = rd_addr;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        wr_ptr_d     = wr_ptr_q;
        wr_wrap_d    = 1'b0;
        rd_valid_d   = grant_rd;
        rd_err_d     = grant_rd & rd_illegal;
        if (grant_wr) begin
            last_grant_d = GNT_WRITE;
            wr_wrap_d    = (wr_addr == LAST_ADDR);
            wr_ptr_d     = (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
        end else if (grant_rd) begin
            last_grant_d = GNT_READ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GNT_READ;
            wr_ptr_q     <= '0;
            wr_wrap_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_wrap_q    <= wr_wrap_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
        end
    end

    assign wr_ready = grant_wr;
    assign rd_gnt   = grant_rd;
    assign wr_ptr   = wr_ptr_q;
    assign wr_wrap  = wr_wrap_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign rd_data  = rd_err_q ? '0 : ram_q;

endmodule

// File: tb/tb_prebuf_arbiter.sv
// Bench for prebuf_arbiter: a behavioural RAM, a shadow-memory reference model, and directed plus random scenarios.
module tb_prebuf_arbiter;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int MS = 3840;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid, wr_sof, wr_ready, wr_wrap;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_ptr;
    logic          rd_req, rd_gnt, rd_valid, rd_err;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          ram_ce, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d, ram_q;

    int checks = 0;
    int errors = 0;

    prebuf_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_sof(wr_sof), .wr_ready(wr_ready),
        .wr_wrap(wr_wrap), .wr_ptr(wr_ptr),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
        .rd_err(rd_err), .rd_data(rd_data),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read data.
    logic [DW-1:0] ram_mem [0:MS-1];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) ram_mem[ram_addr] <= ram_d;
            else        ram_q <= ram_mem[ram_addr];
        end
    end

    // Reference model state.
    int            m_ptr;
    bit            m_pref_w;
    bit            m_wrap;
    logic [DW-1:0] m_mem [0:MS-1];
    bit            m_known [0:MS-1];
    bit            m_rv, m_rerr, m_rknown;
    logic [DW-1:0] m_rdata;
    byte           last_kind;

    task automatic model_reset();
        m_ptr    = 0;
        m_pref_w = 1'b1;
        m_wrap   = 1'b0;
        m_rv     = 1'b0;
        m_rerr   = 1'b0;
    endtask

    task automatic step(input logic wv, input logic [DW-1:0] wd, input logic sof,
                        input logic rr, input logic [AW-1:0] ra);
        bit gw, gr, ill;
        int wa;
        wr_valid = wv; wr_data = wd; wr_sof = sof; rd_req = rr; rd_addr = ra;
        #3;
        gw  = wv && (!rr || m_pref_w);
        gr  = rr && !gw;
        ill = (int'(ra) >= MS);
        wa  = sof ? 0 : m_ptr;
        checks++;
        if (wr_ready !== gw || rd_gnt !== gr) begin
            errors++;
            $display("FAIL grant: wr_ready=%b rd_gnt=%b expected %b %b", wr_ready, rd_gnt, gw, gr);
        end
        checks++;
        if (gw && (ram_ce !== 1'b1 || ram_we !== 1'b1 || int'(ram_addr) != wa || ram_d !== wd)) begin
            errors++;
            $display("FAIL ram_write: ce=%b we=%b addr=%0d d=%h expected 1 1 %0d %h",
                     ram_ce, ram_we, ram_addr, ram_d, wa, wd);
        end else if (gr && (ram_ce !== !ill || ram_we !== 1'b0 || (!ill && ram_addr !== ra))) begin
            errors++;
            $display("FAIL ram_read: ce=%b we=%b addr=%0d expected ce=%b we=0 addr=%0d",
                     ram_ce, ram_we, ram_addr, !ill, ra);
        end else if (!gw && !gr && (ram_ce !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_d !== '0)) begin
            errors++;
            $display("FAIL ram_idle: ce=%b we=%b addr=%0d d=%h expected all zero",
                     ram_ce, ram_we, ram_addr, ram_d);
        end
        @(posedge clk);
        if (gw) begin
            m_mem[wa]   = wd;
            m_known[wa] = 1'b1;
            m_wrap      = (wa == MS-1);
            m_ptr       = (wa == MS-1) ? 0 : wa + 1;
            m_pref_w    = 1'b0;
            last_kind   = "W";
        end else begin
            m_wrap = 1'b0;
            if (gr) begin
                m_pref_w  = 1'b1;
                last_kind = "R";
            end else begin
                last_kind = "-";
            end
        end
        m_rv     = gr;
        m_rerr   = gr && ill;
        m_rknown = ill || m_known[ill ? 0 : int'(ra)];
        m_rdata  = ill ? '0 : m_mem[ill ? 0 : int'(ra)];
        #1;
        checks++;
        if (int'(wr_ptr) != m_ptr || wr_wrap !== m_wrap) begin
            errors++;
            $display("FAIL wr_state: wr_ptr=%0d wr_wrap=%b expected %0d %b", wr_ptr, wr_wrap, m_ptr, m_wrap);
        end
        checks++;
        if (rd_valid !== m_rv || (m_rv && rd_err !== m_rerr)) begin
            errors++;
            $display("FAIL rd_flags: rd_valid=%b rd_err=%b expected %b %b", rd_valid, rd_err, m_rv, m_rerr);
        end
        if (m_rv && m_rknown) begin
            checks++;
            if (rd_data !== m_rdata) begin
                errors++;
                $display("FAIL rd_data: got %h expected %h", rd_data, m_rdata);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 0; wr_data = '0; wr_sof = 0; rd_req = 0; rd_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_ptr !== '0 || wr_wrap !== 1'b0 || rd_valid !== 1'b0 || rd_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ptr=%0d wrap=%b rv=%b err=%b expected 0 0 0 0",
                     wr_ptr, wr_wrap, rd_valid, rd_err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_writes();
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0011 + 16'(i), 1'b0, 1'b0, '0);
        checks++;
        if (wr_ptr !== 12'd5) begin
            errors++;
            $display("FAIL writes_ptr: got %0d expected 5", wr_ptr);
        end
    endtask

    task automatic test_reads();
        step(1'b0, '0, 1'b0, 1'b1, 12'd2);
        checks++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_data !== 16'h0013) begin
            errors++;
            $display("FAIL read_addr2: rv=%b err=%b data=%h expected 1 0 0013", rd_valid, rd_err, rd_data);
        end
        step(1'b0, '0, 1'b0, 1'b1, 12'd4);
        checks++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_data !== 16'h0015) begin
            errors++;
            $display("FAIL read_addr4: rv=%b err=%b data=%h expected 1 0 0015", rd_valid, rd_err, rd_data);
        end
        step(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_contention();
        string seq = "";
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 16'($urandom), 1'b0, 1'b1, 12'($urandom_range(0, 7)));
            seq = {seq, string'(last_kind)};
        end
        checks++;
        if (seq != "WRWRWR") begin
            errors++;
            $display("FAIL contention_order: got %s expected WRWRWR", seq);
        end
        step(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_wrap();
        int pulses = 0;
        step(1'b1, 16'($urandom), 1'b1, 1'b0, '0);
        for (int a = 1; a < MS; a++) begin
            step(1'b1, 16'($urandom), 1'b0, 1'b0, '0);
            if (wr_wrap) pulses++;
        end
        checks++;
        if (pulses != 1 || wr_wrap !== 1'b1 || wr_ptr !== '0) begin
            errors++;
            $display("FAIL wrap_pulse: pulses=%0d wrap=%b ptr=%0d expected 1 1 0", pulses, wr_wrap, wr_ptr);
        end
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, '0);
        checks++;
        if (wr_ptr !== 12'd1 || wr_wrap !== 1'b0 || ram_mem[0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL wrap_next: ptr=%0d wrap=%b mem0=%h expected 1 0 beef", wr_ptr, wr_wrap, ram_mem[0]);
        end
    endtask

    task automatic test_sof();
        while (int'(wr_ptr) != 100) step(1'b1, 16'($urandom), 1'b0, 1'b0, '0);
        step(1'b1, 16'h5A5A, 1'b1, 1'b1, 12'd7);
        checks++;
        if (wr_ptr !== 12'd100 || last_kind != "R") begin
            errors++;
            $display("FAIL sof_stall: ptr=%0d grant=%s expected 100 R", wr_ptr, string'(last_kind));
        end
        step(1'b1, 16'h5A5A, 1'b1, 1'b0, '0);
        checks++;
        if (wr_ptr !== 12'd1 || ram_mem[0] !== 16'h5A5A) begin
            errors++;
            $display("FAIL sof_write: ptr=%0d mem0=%h expected 1 5a5a", wr_ptr, ram_mem[0]);
        end
    endtask

    task automatic test_illegal_and_reset();
        step(1'b0, '0, 1'b0, 1'b1, 12'd3840);
        checks++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_data !== '0) begin
            errors++;
            $display("FAIL illegal_read: rv=%b err=%b data=%h expected 1 1 0000", rd_valid, rd_err, rd_data);
        end
        step(1'b0, '0, 1'b0, 1'b0, '0);
        // Legal read granted, then reset lands before that result can register.
        rd_req = 1'b1; rd_addr = 12'd3;
        #3;
        checks++;
        if (rd_gnt !== 1'b1 || ram_ce !== 1'b1) begin
            errors++;
            $display("FAIL inflight_gnt: gnt=%b ce=%b expected 1 1", rd_gnt, ram_ce);
        end
        #1 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (rd_gnt !== 1'b1) begin
            errors++;
            $display("FAIL reset_comb: rd_gnt=%b expected 1 while in reset", rd_gnt);
        end
        rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rd_valid !== 1'b0 || wr_ptr !== '0) begin
                errors++;
                $display("FAIL inflight_drop: rv=%b ptr=%0d expected 0 0", rd_valid, wr_ptr);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] ra;
            ra = ($urandom_range(0, 7) == 0) ? 12'(MS + $urandom_range(0, 255)) : 12'($urandom_range(0, MS-1));
            step(1'($urandom), 16'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom), ra);
        end
    endtask

    initial begin
        for (int i = 0; i < MS; i++) m_known[i] = 1'b0;
        last_kind = "-";
        test_reset();
        test_writes();
        test_reads();
        test_contention();
        test_wrap();
        test_sof();
        test_illegal_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1);
    end
endmodule
